// File: rtl/bf_stage_reg.sv
// bf_stage_reg -- parametrised MIPS pipeline stage register (IF/ID, ID/EX,
// EX/MEM, MEM/WB) with a valid/ready handshake, synchronous flush, an
// optional one-entry skid buffer and a saturating stall-cycle counter.
//
// Ports:
//   clk_BF        clock, rising edge
//   rstn_BF       synchronous active-low reset
//   flush_BF      synchronous flush; drops every held entry and any input
//   in_valid_BF   upstream entry valid
//   in_ready_BF   stage accepts an entry this cycle
//                 (SKID=1: from flops; SKID=0: combinational from out_ready_BF)
//   in_data_BF    payload in  [DATA_W]
//   in_ctrl_BF    control in  [CTRL_W]
//   out_valid_BF  output entry valid
//   out_ready_BF  downstream accepts this cycle
//   out_data_BF   payload out [DATA_W]
//   out_ctrl_BF   control out [CTRL_W], zero whenever out_valid_BF is low
//   stall_cnt_BF  saturating count of cycles with out_valid && !out_ready
module bf_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_BF,
  input  logic              rstn_BF,
  input  logic              flush_BF,
  input  logic              in_valid_BF,
  output logic              in_ready_BF,
  input  logic [DATA_W-1:0] in_data_BF,
  input  logic [CTRL_W-1:0] in_ctrl_BF,
  output logic              out_valid_BF,
  input  logic              out_ready_BF,
  output logic [DATA_W-1:0] out_data_BF,
  output logic [CTRL_W-1:0] out_ctrl_BF,
  output logic [CNT_W-1:0]  stall_cnt_BF
);

  logic              w_m_vld;
  logic [DATA_W-1:0] w_m_data;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_xfer  = in_valid_BF && w_in_ready;
  assign w_out_xfer = w_m_vld && out_ready_BF;

  if (SKID != 0) begin : g_skid
    logic              r_m_vld;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              r_s_vld;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic              r_in_ready;
    logic              w_m_take;
    logic              w_s_vld_nxt;

    // M may be (re)loaded when it is empty or its entry leaves this edge.
    assign w_m_take    = w_out_xfer || !r_m_vld;
    // S fills only when an input arrives and M cannot take it.
    assign w_s_vld_nxt = r_s_vld ? !w_out_xfer : (w_in_xfer && !w_m_take);

    always_ff @(posedge clk_BF) begin
      if (!rstn_BF) begin
        r_m_vld    <= 1'b0;
        r_m_data   <= '0;
        r_m_ctrl   <= '0;
        r_s_vld    <= 1'b0;
        r_s_data   <= '0;
        r_s_ctrl   <= '0;
        r_in_ready <= 1'b0;
      end else if (flush_BF) begin
        r_m_vld    <= 1'b0;
        r_s_vld    <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        if (w_m_take) begin
          if (r_s_vld) begin
            // Older entry in S always goes first to keep FIFO order.
            r_m_vld  <= 1'b1;
            r_m_data <= r_s_data;
            r_m_ctrl <= r_s_ctrl;
          end else if (w_in_xfer) begin
            r_m_vld  <= 1'b1;
            r_m_data <= in_data_BF;
            r_m_ctrl <= in_ctrl_BF;
          end else begin
            r_m_vld  <= 1'b0;
          end
        end
        if (!r_s_vld && w_in_xfer && !w_m_take) begin
          r_s_data <= in_data_BF;
          r_s_ctrl <= in_ctrl_BF;
        end
        r_s_vld    <= w_s_vld_nxt;
        r_in_ready <= !w_s_vld_nxt;
      end
    end

    assign w_m_vld    = r_m_vld;
    assign w_m_data   = r_m_data;
    assign w_m_ctrl   = r_m_ctrl;
    assign w_in_ready = r_in_ready;
  end else begin : g_single
    logic              r_m_vld;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              r_live;

    always_ff @(posedge clk_BF) begin
      if (!rstn_BF) begin
        r_m_vld  <= 1'b0;
        r_m_data <= '0;
        r_m_ctrl <= '0;
        r_live   <= 1'b0;
      end else begin
        r_live <= 1'b1;
        if (flush_BF) begin
          r_m_vld <= 1'b0;
        end else if (w_in_xfer) begin
          r_m_vld  <= 1'b1;
          r_m_data <= in_data_BF;
          r_m_ctrl <= in_ctrl_BF;
        end else if (w_out_xfer) begin
          r_m_vld <= 1'b0;
        end
      end
    end

    // r_live holds in_ready low throughout reset and releases it one edge later.
    assign w_m_vld    = r_m_vld;
    assign w_m_data   = r_m_data;
    assign w_m_ctrl   = r_m_ctrl;
    assign w_in_ready = r_live && (!r_m_vld || out_ready_BF);
  end

  always_ff @(posedge clk_BF) begin
    if (!rstn_BF) begin
      r_stall_cnt <= '0;
    end else if (w_m_vld && !out_ready_BF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready_BF  = w_in_ready;
  assign out_valid_BF = w_m_vld;
  assign out_data_BF  = w_m_data;
  // Bubbles carry no control, so no stray MemWrite/RegWrite propagates.
  assign out_ctrl_BF  = w_m_vld ? w_m_ctrl : '0;
  assign stall_cnt_BF = r_stall_cnt;

endmodule

// File: tb/tb_bf_stage_reg.sv
// Directed bench for bf_stage_reg: one SKID=1 instance (CNT_W=4) and one
// SKID=0 instance (CNT_W=16) driven by the same stimulus.
module tb_bf_stage_reg;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic [3:0]  s_cnt;

  logic        n_in_ready, n_out_valid;
  logic [15:0] n_out_data;
  logic [7:0]  n_out_ctrl;
  logic [15:0] n_cnt;

  int unsigned total;
  int unsigned bad;

  bf_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_skid (
    .clk_BF(clk), .rstn_BF(rstn), .flush_BF(flush),
    .in_valid_BF(in_valid), .in_ready_BF(s_in_ready),
    .in_data_BF(in_data), .in_ctrl_BF(in_ctrl),
    .out_valid_BF(s_out_valid), .out_ready_BF(out_ready),
    .out_data_BF(s_out_data), .out_ctrl_BF(s_out_ctrl),
    .stall_cnt_BF(s_cnt)
  );

  bf_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_noskid (
    .clk_BF(clk), .rstn_BF(rstn), .flush_BF(flush),
    .in_valid_BF(in_valid), .in_ready_BF(n_in_ready),
    .in_data_BF(in_data), .in_ctrl_BF(in_ctrl),
    .out_valid_BF(n_out_valid), .out_ready_BF(out_ready),
    .out_data_BF(n_out_data), .out_ctrl_BF(n_out_ctrl),
    .stall_cnt_BF(n_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    push(16'h55, 8'hAA);

    // Reset held 3 cycles with in_valid high
    repeat (3) step();
    chk("rst_s_vld",  s_out_valid, 0);
    chk("rst_s_ctrl", s_out_ctrl,  0);
    chk("rst_s_data", s_out_data,  0);
    chk("rst_s_cnt",  s_cnt,       0);
    chk("rst_s_rdy",  s_in_ready,  0);
    chk("rst_n_vld",  n_out_valid, 0);
    chk("rst_n_ctrl", n_out_ctrl,  0);
    chk("rst_n_cnt",  n_cnt,       0);
    chk("rst_n_rdy",  n_in_ready,  0);
    rstn = 1'b1;
    step();
    chk("rel_s_rdy", s_in_ready,  1);
    chk("rel_n_rdy", n_in_ready,  1);
    chk("rel_s_vld", s_out_valid, 0);
    chk("rel_n_vld", n_out_valid, 0);
    in_valid = 1'b0;

    // Streaming 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(16'(i), 8'(i));
      step();
      chk("str_s_vld",  s_out_valid, 1);
      chk("str_s_data", s_out_data,  32'(i));
      chk("str_s_ctrl", s_out_ctrl,  32'(i));
      chk("str_s_rdy",  s_in_ready,  1);
      chk("str_n_vld",  n_out_valid, 1);
      chk("str_n_data", n_out_data,  32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("str_s_drain", s_out_valid, 0);
    chk("str_n_drain", n_out_valid, 0);
    chk("str_s_cnt",   s_cnt,       0);

    // Back-pressure on the skid instance: A, B, C
    out_ready = 1'b0;
    push(16'h0A, 8'h0A);
    step();
    chk("bp_a_data", s_out_data, 16'h0A);
    chk("bp_a_rdy",  s_in_ready, 1);
    chk("bp_a_cnt",  s_cnt,      0);
    push(16'h0B, 8'h0B);
    step();
    chk("bp_b_rdy",  s_in_ready, 0);
    chk("bp_b_data", s_out_data, 16'h0A);
    chk("bp_b_cnt",  s_cnt,      1);
    push(16'h0C, 8'h0C);
    step();
    chk("bp_c1_rdy", s_in_ready, 0);
    chk("bp_c1_cnt", s_cnt,      2);
    step();
    chk("bp_c2_rdy",  s_in_ready, 0);
    chk("bp_c2_cnt",  s_cnt,      3);
    chk("bp_c2_data", s_out_data, 16'h0A);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", s_out_data,  16'h0B);
    chk("bp_vld_b", s_out_valid, 1);
    chk("bp_rdy_b", s_in_ready,  1);
    chk("bp_cnt_h", s_cnt,       3);
    step();
    chk("bp_out_c", s_out_data,  16'h0C);
    chk("bp_vld_c", s_out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", s_out_valid, 0);

    // Flush while FULL with C presented
    out_ready = 1'b0;
    push(16'h11, 8'h81);
    step();
    push(16'h22, 8'h82);
    step();
    chk("fl_full_rdy", s_in_ready, 0);
    push(16'h33, 8'h83);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_s_vld",  s_out_valid, 0);
    chk("fl_s_ctrl", s_out_ctrl,  0);
    chk("fl_s_rdy",  s_in_ready,  1);
    chk("fl_n_vld",  n_out_valid, 0);
    chk("fl_n_ctrl", n_out_ctrl,  0);
    out_ready = 1'b1;
    push(16'h44, 8'h84);
    step();
    chk("fl_d_s_data", s_out_data, 16'h44);
    chk("fl_d_s_ctrl", s_out_ctrl, 8'h84);
    chk("fl_d_n_data", n_out_data, 16'h44);
    in_valid = 1'b0;
    step();
    chk("fl_after_s", s_out_valid, 0);
    chk("fl_after_n", n_out_valid, 0);

    // Bubble control: 0xFF for one cycle, then 0
    push(16'h77, 8'hFF);
    step();
    chk("bub_s_ff", s_out_ctrl, 8'hFF);
    chk("bub_n_ff", n_out_ctrl, 8'hFF);
    in_valid = 1'b0;
    step();
    chk("bub_s_00", s_out_ctrl, 0);
    chk("bub_n_00", n_out_ctrl, 0);

    // Counter saturation after fresh reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("sat_start", s_cnt, 0);
    out_ready = 1'b0;
    push(16'h99, 8'h09);
    step();
    in_valid = 1'b0;
    chk("sat_cnt0", s_cnt, 0);
    repeat (10) step();
    chk("sat_cnt10", s_cnt, 10);
    repeat (10) step();
    chk("sat_cnt20", s_cnt, 15);
    step();
    chk("sat_hold",   s_cnt, 15);
    chk("n_cnt21",    n_cnt, 21);
    chk("sat_s_rdy",  s_in_ready, 1);
    chk("sat_s_data", s_out_data, 16'h99);

    // SKID=0 in_ready follows out_ready combinationally
    chk("n_rdy_low", n_in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("n_rdy_comb", n_in_ready, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_stage_reg.md
# bf_stage_reg

Parametrised pipeline stage register for the MIPS datapath: the generalised successor to the fixed inter-stage buffers. It carries a data payload and a control-signal bundle from one stage to the next with a valid/ready handshake. It provides stall back-pressure, a synchronous flush that inserts a bubble, an optional skid buffer for full throughput with a registered `in_ready`, and a saturating stall-cycle counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- `DATA_W`, 64: payload width (ALU result, register data, branch target, etc., concatenated by the instantiating stage).
- `CTRL_W`, 8: control-bundle width (WB/M/EX signals). Forced to 0 whenever the output is a bubble.
- `SKID`, 1: 1 adds a 1-entry skid buffer and makes `in_ready` registered. 0 gives a single register and a combinational `in_ready`.
- `CNT_W`, 16: width of the stall counter.

Ports (one clock; reset is synchronous and active-low):
- `clk_BF` input 1: clock, rising edge.
- `rstn_BF` input 1: synchronous active-low reset.
- `flush_BF` input 1: synchronous flush (branch/jump taken).
- `in_valid_BF` input 1: upstream has a valid entry.
- `in_ready_BF` output 1: stage can accept an entry this cycle.
- `in_data_BF` input DATA_W: payload in.
- `in_ctrl_BF` input CTRL_W: control bundle in.
- `out_valid_BF` output 1: output entry is valid.
- `out_ready_BF` input 1: downstream accepts this cycle.
- `out_data_BF` output DATA_W: payload out.
- `out_ctrl_BF` output CTRL_W: control out. All-zero when `out_valid_BF`=0.
- `stall_cnt_BF` output CNT_W: saturating count of stalled cycles.

## Operation
- Transfers:
  - Input transfer = `in_valid_BF && in_ready_BF` at a rising edge.
  - Output transfer = `out_valid_BF && out_ready_BF`.
- Storage: main register M (valid, data, ctrl). When SKID=1, also skid register S (valid, data, ctrl).
- SKID=0:
  - `in_ready_BF = !M.valid || out_ready_BF` (combinational).
  - On input transfer, M loads the input.
  - On output transfer without input transfer, M.valid clears.
- SKID=1:
  - `in_ready_BF = !S.valid` (registered).
  - States:
    - EMPTY (M=0, S=0).
    - ONE (M=1, S=0).
    - FULL (M=1, S=1).
  - EMPTY, input → ONE.
  - ONE:
    - input with output → ONE (M replaced).
    - input without output → FULL (input into S).
    - output without input → EMPTY.
  - FULL:
    - output → ONE (S moves to M, S clears).
    - no output → FULL (hold).
    - `in_ready_BF`=0, so no input is possible.
- Ordering: strictly FIFO. No entry is ever dropped or duplicated except by flush.
- Outputs: `out_data_BF` = M.data, always driven. `out_ctrl_BF` = M.valid ? M.ctrl : 0, so no spurious MemWrite/RegWrite leaves a bubble.
- Flush:
  - At the edge, M.valid and S.valid clear.
  - An input presented in the same cycle is discarded.
  - Data registers need not clear.
- Stall counter: increments each cycle with `out_valid_BF && !out_ready_BF`. Saturates at 2^CNT_W−1. Cleared only by reset; not cleared by flush.
- Priority: reset > flush > handshake updates.

## Timing
- Latency: an entry accepted at edge N is presented on `out_*` after edge N.
- Throughput: 1 entry/cycle when `out_ready_BF` is held high, in both SKID modes.
- Reset values (while `rstn_BF`=0 and after the releasing edge):
  - `out_valid_BF`=0, `out_ctrl_BF`=0, `out_data_BF`=0, `stall_cnt_BF`=0.
  - `in_ready_BF`=0 while reset is low; 1 in the first cycle after release.
- Reset mid-operation: all stored entries are lost at that edge.
- `in_ready_BF` with SKID=1 depends only on flops. With SKID=0 it has a combinational path from `out_ready_BF`.
- Handshake rules:
  - Upstream must not drop `in_valid_BF` or change `in_*` until transfer; the block does not check this.
  - `out_valid_BF` never falls without an output transfer, except on flush or reset.
- Flush while FULL: both entries drop. State is EMPTY next cycle and `in_ready_BF`=1.

## Test plan
- Reset: hold `rstn_BF`=0 for 3 cycles with `in_valid_BF`=1 → `out_valid_BF`=0, `out_ctrl_BF`=0, `stall_cnt_BF`=0, `in_ready_BF`=0. After release → `in_ready_BF`=1.
- Streaming: push 0x1..0x8, one per cycle, with `out_ready_BF`=1 → outputs 0x1..0x8 on consecutive cycles, 1 cycle after each accept, no gaps, for SKID=0 and SKID=1.
- Back-pressure (SKID=1): push A, B, C with `out_ready_BF`=0.
  - A and B accepted; `in_ready_BF`=0 while C waits; `stall_cnt_BF` increments each cycle.
  - Then raise `out_ready_BF` → A, B, C delivered in order.
- Flush: with state FULL (A, B) and C presented, assert `flush_BF` one cycle → `out_valid_BF`=0 next cycle, `out_ctrl_BF`=0, C never appears. The next push D appears as the first output.
- Bubble control: enter `in_ctrl_BF`=0xFF then idle → `out_ctrl_BF`=0xFF for one cycle, then 0x00, while `out_data_BF` may hold its value.
- Counter saturation (CNT_W=4): stall for 20 cycles → `stall_cnt_BF` reaches 15 and holds.
